// File: rtl/sar_mc_ctrl.sv
// sar_mc_ctrl: multi-channel SAR conversion sequencer.
// Drives the S/H sample strobe, the SAR DAC trial word and the channel mux,
// resolves one bit per clock and hands results out through a ready/valid
// register with sticky overrun detection.
// Optional feature macro: SAR_AVG_EN (average 2^AVG_LOG2 conversions per result).
module sar_mc_ctrl #(
  parameter int  ADC_BIT    = 8,
  parameter int  NUM_CH     = 4,
  parameter int  SAMPLE_CYC = 2,
  parameter int  AVG_LOG2   = 2,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cont,
  input  logic [NUM_CH-1:0]  ch_en,
  input  logic               cmp_in,
  output logic               sample,
  output logic [CH_W-1:0]    ch_sel,
  output logic [ADC_BIT-1:0] dac_code,
  output logic               busy,
  output logic [ADC_BIT-1:0] dout,
  output logic [CH_W-1:0]    dout_ch,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               overrun
);

  // One counter serves both the sample hold time and the bit index.
  localparam int CNT_MAX = (SAMPLE_CYC > ADC_BIT) ? SAMPLE_CYC : ADC_BIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  if (NUM_CH < 1 || SAMPLE_CYC < 1 || ADC_BIT < 1 || AVG_LOG2 < 0) begin : g_bad_param
    $error("sar_mc_ctrl: illegal parameter value");
  end

  typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_CONV, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADC_BIT-1:0] code_q, code_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [CH_W-1:0]    rr_q, rr_d;
  logic [ADC_BIT-1:0] dout_q, dout_d;
  logic [CH_W-1:0]    dout_ch_q, dout_ch_d;
  logic               dout_valid_q, dout_valid_d;
  logic               overrun_q, overrun_d;

  logic               any_en;
  logic [CH_W-1:0]    nxt_ch;
  logic [ADC_BIT-1:0] bit_mask;
  logic [ADC_BIT-1:0] result;
  logic               grp_last;

  // First enabled channel strictly after ptr, wrapping; nearest candidate wins.
  function automatic logic [CH_W-1:0] pick_next(input logic [CH_W-1:0] ptr,
                                                input logic [NUM_CH-1:0] en);
    logic [CH_W-1:0] sel;
    logic [CH_W-1:0] cand;
    sel = ptr;
    for (int i = NUM_CH; i >= 1; i--) begin
      cand = CH_W'((int'(ptr) + i) % NUM_CH);
      if (en[cand]) sel = cand;
    end
    return sel;
  endfunction

  assign any_en   = |ch_en;
  assign nxt_ch   = pick_next(rr_q, ch_en);
  assign bit_mask = ADC_BIT'(1) << cnt_q;

`ifdef SAR_AVG_EN
  localparam int ACC_W = ADC_BIT + AVG_LOG2;
  localparam int GRP_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic [GRP_W-1:0] grp_q, grp_d;

  assign acc_sum  = acc_q + ACC_W'(code_q);
  assign grp_last = (grp_q == GRP_W'((1 << AVG_LOG2) - 1));
  assign result   = ADC_BIT'(acc_sum >> AVG_LOG2);
`else
  assign grp_last = 1'b1;
  assign result   = code_q;
`endif

  assign sample     = (state_q == S_SAMPLE);
  assign busy       = (state_q != S_IDLE);
  assign ch_sel     = ch_q;
  assign dout       = dout_q;
  assign dout_ch    = dout_ch_q;
  assign dout_valid = dout_valid_q;
  assign overrun    = overrun_q;

  // DAC word: trial bit on top of resolved bits while converting, final code in DONE.
  always_comb begin
    dac_code = '0;
    case (state_q)
      S_CONV:  dac_code = code_q | bit_mask;
      S_DONE:  dac_code = code_q;
      default: dac_code = '0;
    endcase
  end

  // Next-state logic: sequencing, bit resolution, channel pick and result hand-off.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    code_d       = code_q;
    ch_d         = ch_q;
    rr_d         = rr_q;
    dout_d       = dout_q;
    dout_ch_d    = dout_ch_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = overrun_q;
`ifdef SAR_AVG_EN
    acc_d        = acc_q;
    grp_d        = grp_q;
`endif

    // Consumer transfer; a DONE load on the same edge overrides this below.
    if (dout_valid_q && dout_ready) dout_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if ((start || cont) && any_en) begin
          state_d = S_SAMPLE;
          ch_d    = nxt_ch;
          rr_d    = nxt_ch;
          cnt_d   = '0;
          code_d  = '0;
        end
      end
      S_SAMPLE: begin
        if (cnt_q == CNT_W'(SAMPLE_CYC - 1)) begin
          state_d = S_CONV;
          cnt_d   = CNT_W'(ADC_BIT - 1);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CONV: begin
        code_d = code_q | ({ADC_BIT{cmp_in}} & bit_mask);
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_DONE: begin
        cnt_d  = '0;
        code_d = '0;
`ifdef SAR_AVG_EN
        if (grp_last) begin
          acc_d = '0;
          grp_d = '0;
        end else begin
          acc_d = acc_sum;
          grp_d = grp_q + 1'b1;
        end
`endif
        if (grp_last) begin
          // A same-edge transfer frees the register, so only a stalled consumer drops data.
          if (!dout_valid_q || dout_ready) begin
            dout_d       = result;
            dout_ch_d    = ch_q;
            dout_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
          if (cont && any_en) begin
            state_d = S_SAMPLE;
            ch_d    = nxt_ch;
            rr_d    = nxt_ch;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          // Mid-group: resample the same channel regardless of cont.
          state_d = S_SAMPLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset; reset also discards any pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      code_q       <= '0;
      ch_q         <= '0;
      rr_q         <= CH_W'(NUM_CH - 1);
      dout_q       <= '0;
      dout_ch_q    <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SAR_AVG_EN
      acc_q        <= '0;
      grp_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      code_q       <= code_d;
      ch_q         <= ch_d;
      rr_q         <= rr_d;
      dout_q       <= dout_d;
      dout_ch_q    <= dout_ch_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
`ifdef SAR_AVG_EN
      acc_q        <= acc_d;
      grp_q        <= grp_d;
`endif
    end
  end

endmodule
